// File: rtl/datamover_job_scheduler.sv
// rtl/datamover_job_scheduler.sv - round-robin descriptor intake, in-order job queue and streamer launch sequencer
module datamover_job_scheduler #(
    parameter int N_REQ       = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_src_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_dst_i,
    input  logic [N_REQ-1:0][LEN_W-1:0]  req_len_i,
    output logic [ADDR_W-1:0]            job_src_o,
    output logic [ADDR_W-1:0]            job_dst_o,
    output logic [LEN_W-1:0]             job_len_o,
    output logic                         job_start_o,
    input  logic                         job_done_i,
    output logic                         cpl_valid_o,
    output logic [ID_W-1:0]              cpl_id_o,
    output logic                         busy_o,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count_o
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, RUN, CPL} state_t;

    state_t state, state_n;
    logic   flush;
    logic   push, pop;
    logic   found;
    int     arb_idx;
    logic [ID_W-1:0]  arb_sel;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic [ADDR_W-1:0] q_src [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_dst [QUEUE_DEPTH];
    logic [LEN_W-1:0]  q_len [QUEUE_DEPTH];
    logic [ID_W-1:0]   q_id  [QUEUE_DEPTH];

    assign flush = rst_i | clear_i;

    // Search starts one past the last granted requester; no grant while full,
    // even if the head is being popped this cycle.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        arb_idx  = 0;
        arb_sel  = '0;
        if (!flush && queue_count_o < CNT_W'(QUEUE_DEPTH)) begin
            for (int i = 1; i <= N_REQ; i++) begin
                arb_idx = (int'(rr_ptr) + i) % N_REQ;
                arb_sel = ID_W'(arb_idx);
                if (!found && req_valid_i[arb_sel]) begin
                    found          = 1'b1;
                    grant[arb_sel] = 1'b1;
                    grant_id       = arb_sel;
                end
            end
        end
    end

    assign req_ready_o = grant;
    assign push        = found;
    assign pop         = !flush && state == IDLE && queue_count_o != '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_src[wr_ptr] <= req_src_i[grant_id];
            q_dst[wr_ptr] <= req_dst_i[grant_id];
            q_len[wr_ptr] <= req_len_i[grant_id];
            q_id[wr_ptr]  <= grant_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            queue_count_o <= '0;
            rr_ptr        <= ID_W'(N_REQ - 1);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant_id;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      queue_count_o <= queue_count_o + 1'b1;
            else if (!push && pop) queue_count_o <= queue_count_o - 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (queue_count_o != '0) state_n = (q_len[rd_ptr] == '0) ? CPL : START;
            START:   state_n = RUN;
            RUN:     if (job_done_i) state_n = CPL;
            CPL:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (flush) state <= IDLE;
        else       state <= state_n;
    end

    // Job registers hold from one pop to the next so the streamer sees stable config.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            job_src_o <= '0;
            job_dst_o <= '0;
            job_len_o <= '0;
            cpl_id_o  <= '0;
        end else if (pop) begin
            job_src_o <= q_src[rd_ptr];
            job_dst_o <= q_dst[rd_ptr];
            job_len_o <= q_len[rd_ptr];
            cpl_id_o  <= q_id[rd_ptr];
        end
    end

    assign job_start_o = state == START;
    assign cpl_valid_o = state == CPL;
    assign busy_o      = state != IDLE || queue_count_o != '0;
endmodule

// File: tb/tb_datamover_job_scheduler.sv
// tb/tb_datamover_job_scheduler.sv - table vectors plus scoreboard-checked corner sequences
module tb_datamover_job_scheduler;
    logic             clk_i = 1'b0;
    logic             rst_i, clear_i, job_done_i;
    logic [3:0]       req_valid_i, req_ready_o;
    logic [3:0][31:0] req_src_i, req_dst_i, req_len_i;
    logic [31:0]      job_src_o, job_dst_o, job_len_o;
    logic             job_start_o, cpl_valid_o, busy_o;
    logic [1:0]       cpl_id_o;
    logic [2:0]       queue_count_o;

    datamover_job_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_src_i(req_src_i), .req_dst_i(req_dst_i), .req_len_i(req_len_i),
        .job_src_o(job_src_o), .job_dst_o(job_dst_o), .job_len_o(job_len_o),
        .job_start_o(job_start_o), .job_done_i(job_done_i),
        .cpl_valid_o(cpl_valid_o), .cpl_id_o(cpl_id_o),
        .busy_o(busy_o), .queue_count_o(queue_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] src, dst, len;
        int          id;
    } sb_t;

    typedef struct {
        int          req;
        logic [31:0] src, dst, len;
        int          lat;
        int          exp_start;
        int          exp_cpl;
    } vec_t;

    sb_t  sb[$];
    int   grant_log[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, cd = 0, done_lat = 2;
    int   n_start = 0, n_cpl = 0;
    int   last_acc_cyc = 0, last_start_cyc = 0, last_cpl_cyc = 0, last_cpl_id = 0;
    int   n_start0, n_cpl0;
    logic auto_done = 1'b1, man_done = 1'b0, hold_valid = 1'b0, started = 1'b0, pulse;
    logic [3:0] acc_flags = '0;
    vec_t vt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout at cycle %0d", name, cyc);
    endtask

    // One clock: sample/score at negedge, drive streamer done, advance past posedge.
    task automatic step();
        @(negedge clk_i);
        if (rst_i || clear_i) begin
            sb.delete();
            started = 1'b0;
            cd      = 0;
        end else begin
            for (int r = 0; r < 4; r++)
                if (req_valid_i[r] && req_ready_o[r]) begin
                    sb.push_back('{req_src_i[r], req_dst_i[r], req_len_i[r], r});
                    grant_log.push_back(r);
                    acc_flags[r] = 1'b1;
                    last_acc_cyc = cyc;
                end
            if (job_start_o) begin
                n_start++;
                last_start_cyc = cyc;
                if (sb.size() == 0) expire("start_without_job");
                else begin
                    chk("start_src", job_src_o, sb[0].src);
                    chk("start_dst", job_dst_o, sb[0].dst);
                    chk("start_len", job_len_o, sb[0].len);
                    chk("start_nonzero", sb[0].len != 0, 1);
                    started = 1'b1;
                end
            end
            if (cpl_valid_o) begin
                n_cpl++;
                last_cpl_cyc = cyc;
                last_cpl_id  = cpl_id_o;
                if (sb.size() == 0) expire("cpl_without_job");
                else begin
                    chk("cpl_id", cpl_id_o, sb[0].id);
                    chk("cpl_started", started, sb[0].len != 0);
                    void'(sb.pop_front());
                    started = 1'b0;
                end
            end
        end
        pulse = 1'b0;
        if (auto_done) begin
            if (job_start_o) cd = done_lat;
            else if (cd > 0) begin
                cd--;
                pulse = (cd == 0);
            end
        end
        job_done_i = pulse | man_done;
        @(posedge clk_i);
        cyc++;
        #1;
        if (!hold_valid) req_valid_i = req_valid_i & ~acc_flags;
        acc_flags = '0;
    endtask

    task automatic wait_accepted(input string name);
        int k = 0;
        while (req_valid_i != '0 && k < 40) begin step(); k++; end
        if (req_valid_i != '0) begin expire(name); req_valid_i = '0; end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((sb.size() != 0 || busy_o) && k < 300) begin step(); k++; end
        if (sb.size() != 0 || busy_o) expire(name);
    endtask

    task automatic set_req(input int r, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        req_src_i[r] = s;
        req_dst_i[r] = d;
        req_len_i[r] = l;
        req_valid_i[r] = 1'b1;
    endtask

    initial begin
        vt[0] = '{2, 32'h0000_1000, 32'h0000_2000, 32'd16,       8, 2, 11};
        vt[1] = '{0, 32'hFFFF_FFFC, 32'h0000_0000, 32'd1,        1, 2, 4};
        vt[2] = '{3, 32'hA5A5_0000, 32'h5A5A_0000, 32'd0,        0, -1, 2};
        vt[3] = '{1, 32'h0000_0040, 32'hDEAD_BEE0, 32'hFFFF_FFFF, 3, 2, 6};

        rst_i = 1'b1; clear_i = 1'b0; job_done_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            req_src_i[r] = 32'h100 * (r + 1);
            req_dst_i[r] = 32'h8000 + 32'h10 * r;
            req_len_i[r] = 32'd4 + r;
        end
        req_valid_i = 4'hF;
        hold_valid  = 1'b1;
        step(); step();
        chk("rst_ready", req_ready_o, 0);
        chk("rst_start", job_start_o, 0);
        chk("rst_cpl", cpl_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", queue_count_o, 0);
        chk("rst_job", {job_src_o, job_dst_o, job_len_o, cpl_id_o}, 0);

        // Round-robin with all requesters held valid from reset
        rst_i = 1'b0; auto_done = 1'b1; done_lat = 3;
        begin
            int k = 0;
            while (grant_log.size() < 5 && k < 40) begin step(); k++; end
        end
        req_valid_i = '0;
        hold_valid  = 1'b0;
        chk("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("rr_order_%0d", i), grant_log[i], i % 4);
        wait_idle("rr_drain");

        // Table-driven single jobs
        for (int v = 0; v < 4; v++) begin
            done_lat = vt[v].lat;
            n_start0 = n_start;
            n_cpl0   = n_cpl;
            set_req(vt[v].req, vt[v].src, vt[v].dst, vt[v].len);
            wait_accepted($sformatf("vec%0d_accept", v));
            begin
                int k = 0;
                while (n_cpl == n_cpl0 && k < 60) begin step(); k++; end
            end
            if (n_cpl == n_cpl0) expire($sformatf("vec%0d_cpl", v));
            if (vt[v].exp_start >= 0)
                chk($sformatf("vec%0d_start_lat", v), last_start_cyc - last_acc_cyc, vt[v].exp_start);
            else
                chk($sformatf("vec%0d_no_start", v), n_start - n_start0, 0);
            chk($sformatf("vec%0d_cpl_lat", v), last_cpl_cyc - last_acc_cyc, vt[v].exp_cpl);
            chk($sformatf("vec%0d_cpl_id", v), last_cpl_id, vt[v].req);
            wait_idle($sformatf("vec%0d_idle", v));
        end

        // Queue full while job 1 runs
        auto_done = 1'b0;
        n_start0  = n_start;
        set_req(0, 32'h3000, 32'h4000, 32'd8);
        wait_accepted("full_job1_accept");
        begin
            int k = 0;
            while (n_start == n_start0 && k < 10) begin step(); k++; end
        end
        for (int r = 0; r < 4; r++) set_req(r, 32'h5000 + r, 32'h6000 + r, 32'd2 + r);
        wait_accepted("full_fill");
        chk("full_count", queue_count_o, 4);
        set_req(1, 32'h7000, 32'h7100, 32'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_stall_ready", req_ready_o, 0);
        end
        man_done = 1'b1;
        step();
        man_done = 1'b0; auto_done = 1'b1; done_lat = 2;
        chk("full_cpl_pulse", cpl_valid_o, 1);
        chk("full_cpl_ready", req_ready_o, 0);
        step();
        chk("full_pop_ready", req_ready_o, 0);
        chk("full_pop_count", queue_count_o, 4);
        step();
        chk("full_resume_ready", req_ready_o, 4'b0010);
        chk("full_resume_count", queue_count_o, 3);
        wait_accepted("full_fifth_accept");
        wait_idle("full_drain");

        // Zero-length job between two len=8 jobs
        n_start0 = n_start;
        n_cpl0   = n_cpl;
        set_req(0, 32'h0900, 32'h0A00, 32'd8);
        set_req(1, 32'h0B00, 32'h0C00, 32'd0);
        set_req(2, 32'h0D00, 32'h0E00, 32'd8);
        wait_accepted("zero_accept");
        wait_idle("zero_drain");
        chk("zero_starts", n_start - n_start0, 2);
        chk("zero_cpls", n_cpl - n_cpl0, 3);

        // Clear while running with two jobs queued
        auto_done = 1'b0;
        n_start0  = n_start;
        set_req(3, 32'h1100, 32'h1200, 32'd8);
        wait_accepted("clr_accept");
        begin
            int k = 0;
            while (n_start == n_start0 && k < 10) begin step(); k++; end
        end
        step();
        set_req(1, 32'h1300, 32'h1400, 32'd8);
        set_req(2, 32'h1500, 32'h1600, 32'd8);
        wait_accepted("clr_queue");
        chk("clr_pre_count", queue_count_o, 2);
        n_cpl0  = n_cpl;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_busy", busy_o, 0);
        chk("clr_count", queue_count_o, 0);
        chk("clr_cpl", cpl_valid_o, 0);
        chk("clr_job_len", job_len_o, 0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step(); step(); step();
        chk("clr_no_cpl", n_cpl - n_cpl0, 0);
        chk("clr_still_idle", busy_o, 0);

        // Spurious done in IDLE, then in the pop and START cycles
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("spur_idle_busy", busy_o, 0);
        chk("spur_idle_cpl", n_cpl - n_cpl0, 0);
        set_req(2, 32'h2100, 32'h2200, 32'd4);
        wait_accepted("spur_accept");
        man_done = 1'b1;
        step(); step();
        man_done = 1'b0;
        chk("spur_start_lat", last_start_cyc - last_acc_cyc, 2);
        chk("spur_run_cpl", cpl_valid_o, 0);
        chk("spur_run_busy", busy_o, 1);
        step(); step();
        chk("spur_no_cpl", n_cpl - n_cpl0, 0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("spur_real_cpl", n_cpl - n_cpl0, 1);
        wait_idle("spur_drain");
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
